// File: rtl/edge_window_sequencer.sv
// Raster sequencer for the 3x3 edge datapath: tracks col/row of the accepted pixel stream,
// produces the advance strobe, masks the priming border and reports frame completion/errors.
module edge_window_sequencer #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_valid_in,
    input  logic          sof_in,
    input  logic [7:0]    pix_in,
    output logic [7:0]    pix_out,
    output logic [CW-1:0] col_out,
    output logic [CW-1:0] row_out,
    output logic          adv,
    output logic          win_valid,
    output logic          frame_done,
    output logic          sof_err,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);

    state_t        state_q;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          in_frame;
    logic          accept;

    assign in_frame = (state_q == PRIME) || (state_q == STREAM);
    assign accept   = pix_valid_in && (sof_in || in_frame);
    assign state    = state_q;

    // col/row always hold the position the next accepted pixel will take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col        <= '0;
            row        <= '0;
            pix_out    <= '0;
            col_out    <= '0;
            row_out    <= '0;
            adv        <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            adv        <= accept;
            win_valid  <= 1'b0;
            sof_err    <= 1'b0;
            frame_done <= (state_q == DONE);
            if (accept) begin
                pix_out <= pix_in;
                if (sof_in) begin
                    // A start of frame always wins, even over the last pixel of a frame.
                    col_out <= '0;
                    row_out <= '0;
                    sof_err <= in_frame && ((col != '0) || (row != '0));
                    col     <= CW'(1);
                    row     <= '0;
                    state_q <= PRIME;
                end else begin
                    col_out   <= col;
                    row_out   <= row;
                    win_valid <= (col >= CW'(2)) && (row >= CW'(2));
                    if (col == LAST_COL) begin
                        col <= '0;
                        if (row == LAST_ROW) begin
                            row     <= '0;
                            state_q <= DONE;
                        end else begin
                            row <= row + CW'(1);
                            if (row == CW'(1)) begin
                                state_q <= STREAM;
                            end
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end else if (state_q == DONE) begin
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_edge_window_sequencer.sv
// Self-checking bench for edge_window_sequencer: directed scenarios plus random traffic,
// compared every cycle against a frame-index reference model.
module tb_edge_window_sequencer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 13;

    logic          clk;
    logic          rst_n;
    logic          pix_valid_in;
    logic          sof_in;
    logic [7:0]    pix_in;
    logic [7:0]    pix_out;
    logic [CW-1:0] col_out;
    logic [CW-1:0] row_out;
    logic          adv;
    logic          win_valid;
    logic          frame_done;
    logic          sof_err;
    logic [1:0]    state;

    edge_window_sequencer #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pix_valid_in(pix_valid_in),
        .sof_in(sof_in),
        .pix_in(pix_in),
        .pix_out(pix_out),
        .col_out(col_out),
        .row_out(row_out),
        .adv(adv),
        .win_valid(win_valid),
        .frame_done(frame_done),
        .sof_err(sof_err),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: position is a linear index into the frame, not a col/row pair.
    int p       = 0;
    bit in_fr   = 0;
    bit is_done = 0;
    int exp_pix = 0, exp_col = 0, exp_row = 0;
    bit exp_adv = 0, exp_win = 0, exp_fd = 0, exp_err = 0;
    int exp_state = 0;

    task automatic modelReset();
        p = 0; in_fr = 0; is_done = 0;
        exp_pix = 0; exp_col = 0; exp_row = 0;
        exp_adv = 0; exp_win = 0; exp_fd = 0; exp_err = 0; exp_state = 0;
    endtask

    task automatic modelStep(input bit v, input bit s, input logic [7:0] d);
        bit acc;
        int idx;
        acc    = v && (s || in_fr);
        exp_fd = is_done;
        if (acc) begin
            idx     = s ? 0 : p;
            exp_err = s && in_fr && (p != 0);
            exp_pix = d;
            exp_col = idx % W;
            exp_row = idx / W;
            exp_adv = 1;
            exp_win = (exp_col >= 2) && (exp_row >= 2);
            if (idx + 1 == W * H) begin
                in_fr = 0; is_done = 1; p = 0;
            end else begin
                in_fr = 1; is_done = 0; p = idx + 1;
            end
        end else begin
            exp_adv = 0; exp_win = 0; exp_err = 0;
            is_done = 0;
        end
        exp_state = is_done ? 3 : (in_fr ? ((p >= 2 * W) ? 2 : 1) : 0);
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, "/adv"},        32'(adv),        32'(exp_adv));
        checkOne({tag, "/win_valid"},  32'(win_valid),  32'(exp_win));
        checkOne({tag, "/frame_done"}, 32'(frame_done), 32'(exp_fd));
        checkOne({tag, "/sof_err"},    32'(sof_err),    32'(exp_err));
        checkOne({tag, "/state"},      32'(state),      32'(exp_state));
        checkOne({tag, "/pix_out"},    32'(pix_out),    32'(exp_pix));
        checkOne({tag, "/col_out"},    32'(col_out),    32'(exp_col));
        checkOne({tag, "/row_out"},    32'(row_out),    32'(exp_row));
    endtask

    task automatic applyStimulus(input bit v, input bit s, input logic [7:0] d, input string tag);
        pix_valid_in = v;
        sof_in       = s;
        pix_in       = d;
        @(posedge clk);
        #1;
        modelStep(v, s, d);
        checkOutput(tag);
    endtask

    initial begin
        int win_count;
        int fd_count;
        pix_valid_in = 0; sof_in = 0; pix_in = 0;
        rst_n = 0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset");
        rst_n = 1;

        $display("[TB] full frame with sof on first pixel");
        win_count = 0;
        for (int i = 0; i < W * H; i++) begin
            applyStimulus(1, i == 0, 8'($urandom), "frame");
            if (win_valid) win_count++;
        end
        applyStimulus(0, 0, 8'h00, "frame_end");
        checkOne("frame/win_count", 32'(win_count), 32'd2);
        applyStimulus(0, 0, 8'h00, "frame_idle");

        $display("[TB] valid pixels without sof in idle");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'($urandom), "idle_drop");

        $display("[TB] bubbles every other cycle");
        win_count = 0;
        for (int i = 0; i < 2 * W * H; i++) begin
            applyStimulus(i % 2 == 0, i == 0, 8'($urandom), "bubble");
            if (win_valid) win_count++;
        end
        applyStimulus(0, 0, 8'h00, "bubble_end");
        checkOne("bubble/win_count", 32'(win_count), 32'd2);
        applyStimulus(0, 0, 8'h00, "bubble_idle");

        $display("[TB] sof mid-frame at (2,1)");
        for (int i = 0; i < 6; i++) applyStimulus(1, i == 0, 8'($urandom), "pre_err");
        applyStimulus(1, 1, 8'hA5, "sof_err");
        checkOne("sof_err/pulse", 32'(sof_err), 32'd1);
        for (int i = 0; i < W * H - 1; i++) applyStimulus(1, 0, 8'($urandom), "post_err");
        applyStimulus(0, 0, 8'h00, "post_err_end");
        applyStimulus(0, 0, 8'h00, "post_err_idle");

        $display("[TB] asynchronous reset in STREAM");
        for (int i = 0; i < 10; i++) applyStimulus(1, i == 0, 8'($urandom), "pre_rst");
        checkOne("pre_rst/state", 32'(state), 32'd2);
        #2;
        rst_n = 0;
        #1;
        modelReset();
        checkOutput("async_rst");
        #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 8'($urandom), "post_rst_drop");

        $display("[TB] back-to-back frames");
        for (int i = 0; i < W * H; i++) applyStimulus(1, i == 0, 8'($urandom), "b2b_a");
        fd_count = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, i == 0, 8'($urandom), "b2b_b");
            if (frame_done) fd_count++;
        end
        checkOne("b2b/frame_done_count", 32'(fd_count), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                          8'($urandom), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
